// File: rtl/rt_mem_preloader.sv
// Streams a fixed-size image into memory port B, optionally reads it back and
// compares rotate-xor checksums, then releases the core via fetch_enable_o.
module rt_mem_preloader #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 22,
  parameter int                    NUM_WORDS   = 4088,
  parameter int                    ADDR_STRIDE = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    TIMEOUT     = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               verify_i,
  input  logic                               src_valid_i,
  input  logic [DATA_WIDTH-1:0]              src_data_i,
  output logic                               src_ready_o,
  output logic                               mem_en_o,
  output logic                               mem_we_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic                               fetch_enable_o,
  output logic [1:0]                         err_code_o,
  output logic [ADDR_WIDTH-1:0]              err_addr_o,
  output logic [$clog2(NUM_WORDS+1)-1:0]     word_cnt_o
);

  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FETCH, S_W_REQ, S_W_WAIT, S_W_GAP,
    S_V_REQ, S_V_WAIT, S_V_GAP, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic                    verify_q, verify_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   wsum_q, wsum_d;
  logic [DATA_WIDTH-1:0]   vsum_q, vsum_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    last_word;
  logic                    wait_expired;

  function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction

  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign addr_inc     = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
  assign last_word    = (cnt_inc == CNT_W'(NUM_WORDS));
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      verify_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      cnt_q      <= '0;
      wsum_q     <= '0;
      vsum_q     <= '0;
      word_q     <= '0;
      wait_q     <= '0;
      err_code_q <= 2'd0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      verify_q   <= verify_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wsum_q     <= wsum_d;
      vsum_q     <= vsum_d;
      word_q     <= word_d;
      wait_q     <= wait_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    verify_d       = verify_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    wsum_d         = wsum_q;
    vsum_d         = vsum_q;
    word_d         = word_q;
    wait_d         = wait_q;
    err_code_d     = err_code_q;
    err_addr_d     = err_addr_q;
    src_ready_o    = 1'b0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    done_o         = 1'b0;
    error_o        = 1'b0;
    fetch_enable_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          verify_d = verify_i;
          addr_d   = BASE_ADDR;
          cnt_d    = '0;
          wsum_d   = '0;
          vsum_d   = '0;
          state_d  = S_W_FETCH;
        end
      end
      S_W_FETCH: begin
        src_ready_o = 1'b1;
        if (src_valid_i) begin
          word_d  = src_data_i;
          state_d = S_W_REQ;
        end
      end
      S_W_REQ: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = '1;
        mem_wdata_o = word_q;
        wsum_d      = rotl1(wsum_q) ^ word_q;
        wait_d      = '0;
        state_d     = S_W_WAIT;
      end
      S_W_WAIT, S_V_WAIT: begin
        // Completion wins over an expiring timeout in the same cycle.
        if (mem_rvalid_i) begin
          if (state_q == S_V_WAIT) begin
            vsum_d  = rotl1(vsum_q) ^ mem_rdata_i;
            state_d = S_V_GAP;
          end else begin
            state_d = S_W_GAP;
          end
        end else if (wait_expired) begin
          err_code_d = 2'd1;
          err_addr_d = addr_q;
          state_d    = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_W_GAP: begin
        addr_d = addr_inc;
        cnt_d  = cnt_inc;
        if (!last_word) begin
          state_d = S_W_FETCH;
        end else if (verify_q) begin
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
          state_d = S_V_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_V_REQ: begin
        mem_en_o = 1'b1;
        mem_be_o = '1;
        wait_d   = '0;
        state_d  = S_V_WAIT;
      end
      S_V_GAP: begin
        addr_d = addr_inc;
        cnt_d  = cnt_inc;
        if (!last_word) begin
          state_d = S_V_REQ;
        end else if (vsum_q == wsum_q) begin
          state_d = S_DONE;
        end else begin
          err_code_d = 2'd2;
          err_addr_d = BASE_ADDR;
          state_d    = S_ERR;
        end
      end
      S_DONE: begin
        done_o         = 1'b1;
        fetch_enable_o = 1'b1;
      end
      S_ERR: begin
        error_o = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign mem_addr_o = addr_q;
  assign err_code_o = err_code_q;
  assign err_addr_o = err_addr_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_rt_mem_preloader.sv
// Bench for rt_mem_preloader: directed and randomized image loads checked against
// a transaction-level model (address list, data list, checksum rule, outcome).
`timescale 1ns/1ps
module tb_rt_mem_preloader;
  localparam int DW   = 32;
  localparam int AW_A = 8;
  localparam int NW_A = 4;
  localparam int AW_B = 4;
  localparam int NW_B = 2;
  localparam int TO   = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b, verify, src_valid, rvalid, sel;
  logic [DW-1:0] src_data, rdata;

  logic            a_ready, a_en, a_we, a_busy, a_done, a_error, a_fetch;
  logic [AW_A-1:0] a_addr, a_eaddr;
  logic [DW-1:0]   a_wdata;
  logic [3:0]      a_be;
  logic [1:0]      a_ecode;
  logic [2:0]      a_cnt;

  logic            b_ready, b_en, b_we, b_busy, b_done, b_error, b_fetch;
  logic [AW_B-1:0] b_addr, b_eaddr;
  logic [DW-1:0]   b_wdata;
  logic [3:0]      b_be;
  logic [1:0]      b_ecode;
  logic [1:0]      b_cnt;

  rt_mem_preloader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW_A), .NUM_WORDS(NW_A), .ADDR_STRIDE(4),
    .BASE_ADDR(8'h00), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .verify_i(verify),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(a_ready),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_be_o(a_be), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_error), .fetch_enable_o(a_fetch),
    .err_code_o(a_ecode), .err_addr_o(a_eaddr), .word_cnt_o(a_cnt)
  );

  rt_mem_preloader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW_B), .NUM_WORDS(NW_B), .ADDR_STRIDE(4),
    .BASE_ADDR(4'hC), .TIMEOUT(TO)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .verify_i(verify),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(b_ready),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_be_o(b_be), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .busy_o(b_busy), .done_o(b_done), .error_o(b_error), .fetch_enable_o(b_fetch),
    .err_code_o(b_ecode), .err_addr_o(b_eaddr), .word_cnt_o(b_cnt)
  );

  // Unified view of whichever instance the current operation targets.
  logic        o_ready, o_en, o_we, o_busy, o_done, o_error, o_fetch;
  logic [7:0]  o_addr, o_eaddr, o_cnt;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic [1:0]  o_ecode;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_en    = sel ? b_en    : a_en;
  assign o_we    = sel ? b_we    : a_we;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_error = sel ? b_error : a_error;
  assign o_fetch = sel ? b_fetch : a_fetch;
  assign o_addr  = sel ? {4'b0, b_addr}  : a_addr;
  assign o_eaddr = sel ? {4'b0, b_eaddr} : a_eaddr;
  assign o_cnt   = sel ? {6'b0, b_cnt}   : {5'b0, a_cnt};
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_be    = sel ? b_be    : a_be;
  assign o_ecode = sel ? b_ecode : a_ecode;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] img[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag, input int base);
    chk({tag, "_outs"}, {o_wdata, o_eaddr, o_cnt, o_ready, o_en, o_we, o_be,
                         o_busy, o_done, o_error, o_fetch, o_ecode}, 128'd0);
    chk({tag, "_addr"}, o_addr, base);
  endtask

  function automatic logic [31:0] csum(input logic [31:0] w[$]);
    logic [31:0] s = 32'h0;
    foreach (w[i]) s = {s[30:0], s[31]} ^ w[i];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; src_valid = 1'b0; rvalid = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // One load operation: drives source and memory, records requests, then compares
  // against the expected request list and final status.
  task automatic run_op(input string name, input bit s, input bit vfy, input bit fast,
                        input int corrupt_idx, input int stall_idx, input int abort_idx,
                        input int nw, input int aw, input int base);
    txn_t obs_q[$];
    txn_t exp_q[$];
    txn_t t;
    logic [31:0] mem [int];
    logic [31:0] rb[$];
    logic [31:0] rd_val;
    int widx = 0, nwr = 0, nrd = 0, lat = 0, stall_cnt = 0, busy_cycles = 0;
    int n_exp_w, exp_code, exp_cnt, exp_eaddr;
    bit pending = 0, stalling = 0, last_we = 0, busy_bad = 0, be_bad = 0;
    bit finished = 0, aborted = 0, hold_bad = 0, exp_done, exp_error;
    rd_val = 32'h0;
    sel = s;
    verify = vfy;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (o_done || o_error) begin finished = 1; break; end
      if (o_busy) busy_cycles++; else busy_bad = 1;
      rvalid = 1'b0;
      rdata  = $urandom;
      if (o_en) begin
        if (o_be !== 4'hF) be_bad = 1;
        t.we = o_we; t.addr = 32'(o_addr); t.data = o_we ? o_wdata : 32'h0;
        obs_q.push_back(t);
        last_we = o_we;
        if (o_we) begin
          mem[int'(o_addr)] = o_wdata;
          rd_val = $urandom;
          stalling = (nwr == stall_idx);
          nwr++;
        end else begin
          rd_val = mem.exists(int'(o_addr)) ? mem[int'(o_addr)] : 32'hDEAD_BEEF;
          if (nrd == corrupt_idx) rd_val = rd_val ^ 32'h1;
          nrd++;
        end
        pending = 1;
        lat = fast ? 0 : int'($urandom_range(0, 2));
        // A completion pulse during the request cycle must be ignored.
        if (!fast) rvalid = ($urandom_range(0, 1) == 1);
      end else if (pending) begin
        if (last_we && (nwr - 1 == abort_idx)) begin
          rst = 1'b1; src_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          chk_reset("abort_rst", base);
          aborted = 1;
          break;
        end
        if (stalling) stall_cnt++;
        else if (lat == 0) begin rvalid = 1'b1; rdata = rd_val; pending = 0; end
        else lat--;
      end else if (!fast) begin
        rvalid = ($urandom_range(0, 3) == 0);
      end
      src_valid = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_data  = (widx < img.size()) ? img[widx] : $urandom;
      if (o_ready && src_valid) widx++;
    end
    src_valid = 1'b0; rvalid = 1'b0;
    if (aborted) begin
      $display("op %-8s aborted after %0d writes; outputs back at reset values", name, nwr);
      return;
    end
    chk({name, "_finished"}, finished, 1'b1);

    n_exp_w = (stall_idx >= 0) ? stall_idx + 1 : nw;
    for (int i = 0; i < n_exp_w; i++) begin
      t.we = 1'b1; t.addr = 32'((base + i * 4) % (1 << aw)); t.data = img[i];
      exp_q.push_back(t);
    end
    exp_code = 0; exp_cnt = nw; exp_eaddr = 0;
    if (stall_idx >= 0) begin
      exp_code = 1; exp_cnt = stall_idx; exp_eaddr = (base + stall_idx * 4) % (1 << aw);
    end else if (vfy) begin
      for (int i = 0; i < nw; i++) begin
        t.we = 1'b0; t.addr = 32'((base + i * 4) % (1 << aw)); t.data = 32'h0;
        exp_q.push_back(t);
        rb.push_back(img[i] ^ ((i == corrupt_idx) ? 32'h1 : 32'h0));
      end
      if (csum(rb) != csum(img)) begin exp_code = 2; exp_eaddr = base; end
    end
    exp_error = (exp_code != 0);
    exp_done  = !exp_error;

    chk({name, "_txn_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({name, "_txn"}, obs_q[i], exp_q[i]);
    chk({name, "_done"}, o_done, exp_done);
    chk({name, "_error"}, o_error, exp_error);
    chk({name, "_fetch_en"}, o_fetch, exp_done);
    chk({name, "_err_code"}, o_ecode, exp_code);
    if (exp_error) chk({name, "_err_addr"}, o_eaddr, exp_eaddr);
    chk({name, "_word_cnt"}, o_cnt, exp_cnt);
    chk({name, "_busy_gap"}, busy_bad, 1'b0);
    chk({name, "_be"}, be_bad, 1'b0);
    if (stall_idx >= 0) chk({name, "_wait_cycles"}, stall_cnt, TO);
    if (fast && !vfy && stall_idx < 0) chk({name, "_cycles"}, busy_cycles, 4 * nw);

    // Terminal states hold and ignore further starts and completions.
    for (int k = 0; k < 4; k++) begin
      if (s) start_b = 1'($urandom_range(0, 1)); else start_a = 1'($urandom_range(0, 1));
      src_valid = 1'b1;
      rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (o_done !== exp_done || o_error !== exp_error || o_en !== 1'b0 ||
          o_busy !== 1'b0 || o_ready !== 1'b0) hold_bad = 1;
    end
    start_a = 1'b0; start_b = 1'b0; src_valid = 1'b0; rvalid = 1'b0;
    chk({name, "_hold"}, hold_bad, 1'b0);
    $display("op %-8s verify=%0d writes=%0d reads=%0d done=%0d error=%0d code=%0d cnt=%0d",
             name, vfy, nwr, nrd, o_done, o_error, o_ecode, o_cnt);
  endtask

  initial begin
    int c;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; verify = 1'b0; sel = 1'b0;
    src_valid = 1'b0; src_data = '0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sel = 1'b0; #1;
    chk_reset("reset_a", 0);
    sel = 1'b1; #1;
    chk_reset("reset_b", 12);

    img = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_op("wr_only", 1'b0, 1'b0, 1'b1, -1, -1, -1, NW_A, AW_A, 0);
    do_reset();
    run_op("vfy_ok", 1'b0, 1'b1, 1'b1, -1, -1, -1, NW_A, AW_A, 0);
    do_reset();
    run_op("vfy_bad", 1'b0, 1'b1, 1'b0, 2, -1, -1, NW_A, AW_A, 0);
    do_reset();
    run_op("timeout", 1'b0, 1'b0, 1'b0, -1, 1, -1, NW_A, AW_A, 0);
    do_reset();
    rand_img(NW_A);
    run_op("abort", 1'b0, 1'b1, 1'b0, -1, -1, 1, NW_A, AW_A, 0);
    rand_img(NW_A);
    run_op("restart", 1'b0, 1'b1, 1'b0, -1, -1, -1, NW_A, AW_A, 0);
    do_reset();
    rand_img(NW_B);
    run_op("wrap", 1'b1, 1'b0, 1'b0, -1, -1, -1, NW_B, AW_B, 12);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_img(NW_A);
      c = int'($urandom_range(0, 4));
      run_op("random", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (c == 4) ? -1 : c, -1, -1, NW_A, AW_A, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rt_mem_preloader.md
RT_MEM_PRELOADER -- requirements
Module: rt_mem_preloader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 22: memory byte-address width.
REQ-003 SHALL have parameter NUM_WORDS, default 4088: words per image, range 1..2^20.
REQ-004 SHALL have parameter ADDR_STRIDE, default 4: byte increment per word.
REQ-005 SHALL have parameter BASE_ADDR, default 0: first write address.
REQ-006 SHALL have parameter TIMEOUT, default 64: maximum wait cycles for mem_rvalid_i.
REQ-007 SHALL have port clk_i, input, 1: the only clock; all logic samples on its rising edge.
REQ-008 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start_i, input, 1: start request, sampled only in IDLE.
REQ-010 SHALL have port verify_i, input, 1: enables read-back verify, latched with start_i.
REQ-011 SHALL have ports src_valid_i (input, 1), src_data_i (input, DATA_WIDTH) and src_ready_o (output, 1): image word stream.
REQ-012 SHALL have ports mem_en_o (1), mem_we_o (1), mem_addr_o (ADDR_WIDTH), mem_wdata_o (DATA_WIDTH) and mem_be_o (DATA_WIDTH/8), all outputs: memory port-B request.
REQ-013 SHALL have ports mem_rvalid_i (input, 1) and mem_rdata_i (input, DATA_WIDTH): memory completion and read data.
REQ-014 SHALL have ports busy_o, done_o, error_o and fetch_enable_o, each output, 1: status.
REQ-015 SHALL have ports err_code_o (output, 2; 1 = timeout, 2 = checksum mismatch) and err_addr_o (output, ADDR_WIDTH).
REQ-016 SHALL have port word_cnt_o, output, clog2(NUM_WORDS+1): words completed in the current phase.

Function
REQ-017 SHALL implement the states IDLE, W_FETCH, W_REQ, W_WAIT, W_GAP, V_REQ, V_WAIT, V_GAP, DONE and ERR.
REQ-018 In IDLE with start_i=1, it SHALL latch verify_i, set addr=BASE_ADDR, cnt=0, wsum=0 and vsum=0, then go to W_FETCH.
REQ-019 W_FETCH SHALL drive src_ready_o=1; on src_valid_i=1 it SHALL latch src_data_i and go to W_REQ; src_ready_o SHALL be 0 in every other state.
REQ-020 W_REQ SHALL last exactly 1 cycle with mem_en_o=1, mem_we_o=1, mem_be_o all ones, mem_wdata_o=latched word and mem_addr_o=addr, and SHALL update wsum = rotl(wsum,1) XOR word.
REQ-021 In W_WAIT and V_WAIT, mem_en_o SHALL be 0 and mem_addr_o SHALL hold its value; on mem_rvalid_i=1 the FSM SHALL go to the matching GAP state.
REQ-022 A GAP state SHALL last exactly 1 cycle, perform addr += ADDR_STRIDE (modulo 2^ADDR_WIDTH) and cnt += 1, and choose the next state as follows:
- from W_GAP, if cnt < NUM_WORDS, go to W_FETCH;
- from W_GAP, if cnt == NUM_WORDS and verify is latched, reset addr to BASE_ADDR and cnt to 0 and go to V_REQ;
- from W_GAP, if cnt == NUM_WORDS and verify is not latched, go to DONE.
REQ-023 V_REQ SHALL last exactly 1 cycle with mem_en_o=1, mem_we_o=0 and mem_be_o all ones.
REQ-024 In V_WAIT, when mem_rvalid_i=1, it SHALL update vsum = rotl(vsum,1) XOR mem_rdata_i.
REQ-025 After the last V_GAP, it SHALL go to DONE if vsum==wsum, otherwise to ERR with err_code_o=2 and err_addr_o=BASE_ADDR.
REQ-026 A wait counter SHALL clear on entry to each WAIT state; if TIMEOUT cycles elapse without mem_rvalid_i, the FSM SHALL go to ERR with err_code_o=1 and err_addr_o=current addr.
REQ-027 mem_rvalid_i SHALL be ignored outside the WAIT states, including a pulse coincident with a REQ cycle.
REQ-028 start_i SHALL be ignored outside IDLE.
REQ-029 If src_valid_i=0 in W_FETCH, the FSM SHALL stall indefinitely with no timeout.
REQ-030 busy_o SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-031 DONE SHALL assert done_o=1 and fetch_enable_o=1 and hold them until reset.
REQ-032 ERR SHALL assert error_o=1, keep fetch_enable_o=0 and hold until reset.
REQ-033 word_cnt_o SHALL equal cnt at all times.
REQ-034 Inactive mem_* outputs SHALL be 0, except that mem_addr_o holds its value.
REQ-035 Minimum write-only throughput with 1-cycle memory latency and an always-valid source SHALL be 1 word per 4 cycles.

Reset
REQ-036 With rst_i=1 at a clock edge, the FSM SHALL enter IDLE and every output SHALL be 0, except mem_addr_o=BASE_ADDR.
REQ-037 A reset in any state, including mid-WAIT, SHALL abort the operation.
REQ-038 After an aborted operation, a fresh start_i SHALL restart from BASE_ADDR with the checksums cleared.

Verification
REQ-039 Write-only test: NUM_WORDS=4, data 0x11,0x22,0x33,0x44, 1-cycle rvalid -> writes to addresses 0x0, 0x4, 0x8, 0xC in order, each with en=1 for one cycle; done_o and fetch_enable_o rise; word_cnt_o=4.
REQ-040 Verify pass test: the same image with verify_i=1 and a memory model echoing the stored data -> 4 writes then 4 reads at 0x0..0xC; done_o=1; error_o=0.
REQ-041 Verify fail test: the memory model corrupts bit 0 of the word at 0x8 -> error_o=1, err_code_o=2, fetch_enable_o=0.
REQ-042 Timeout test: TIMEOUT=8 and rvalid withheld on the second write -> after 8 WAIT cycles, error_o=1, err_code_o=1, err_addr_o=0x4.
REQ-043 Reset mid-operation: rst_i asserted in W_WAIT of word 2 -> all outputs 0 on the next cycle; a restart writes address 0x0 first with the checksums cleared.
REQ-044 Wrap test: ADDR_WIDTH=4, BASE_ADDR=0xC, NUM_WORDS=2 -> addresses 0xC then 0x0.
